gpio_irq: RTL and testbench

Parametrised successor to the basic memory-mapped GPIO port. It adds the following on the same simple register bus:
- atomic SET/CLR/TOG output writes
- a configurable-depth input synchroniser
- a per-pin debounce filter with a programmable threshold
- per-pin rise/fall edge detection with sticky, write-1-to-clear status and a single interrupt line.

It sits on the SoC peripheral bus next to the timer and UART, and drives pads through gpio_o/gpio_oe_o.

---
 rtl/gpio_irq.sv | 156 +++++++++++++++
 tb/tb_gpio_irq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq.sv
// gpio_irq: memory-mapped GPIO port with atomic SET/CLR/TOG writes, synchronised and
// debounced inputs, and per-pin rise/fall detection into sticky W1C status with one irq.
module gpio_irq #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 8,
    parameter int DB_RST      = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    input  logic             we_i,
    input  logic             re_i,
    output logic [31:0]      rdata_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe_o,
    output logic             irq_o
);

    // Word offsets (addr_i[7:2]).
    localparam logic [5:0] A_DATA     = 6'h00;
    localparam logic [5:0] A_DIR      = 6'h01;
    localparam logic [5:0] A_INPUT    = 6'h02;
    localparam logic [5:0] A_SET      = 6'h03;
    localparam logic [5:0] A_CLR      = 6'h04;
    localparam logic [5:0] A_TOG      = 6'h05;
    localparam logic [5:0] A_RISE_EN  = 6'h06;
    localparam logic [5:0] A_FALL_EN  = 6'h07;
    localparam logic [5:0] A_STATUS   = 6'h08;
    localparam logic [5:0] A_DEBOUNCE = 6'h09;

    logic [WIDTH-1:0]                  r_data;
    logic [WIDTH-1:0]                  r_dir;
    logic [WIDTH-1:0]                  r_rise_en;
    logic [WIDTH-1:0]                  r_fall_en;
    logic [WIDTH-1:0]                  r_status;
    logic [DB_W-1:0]                   r_debounce;
    logic [31:0]                       r_rdata;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_stb;
    logic [WIDTH-1:0][DB_W-1:0]        r_cnt;

    logic [5:0]                        w_idx;
    logic [WIDTH-1:0]                  w_wdata;
    logic [WIDTH-1:0]                  w_sync_out;
    logic [WIDTH-1:0]                  w_stb_next;
    logic [WIDTH-1:0][DB_W-1:0]        w_cnt_next;
    logic [WIDTH-1:0]                  w_rise;
    logic [WIDTH-1:0]                  w_fall;
    logic [WIDTH-1:0]                  w_w1c;
    logic [WIDTH-1:0]                  w_status_next;
    logic [31:0]                       w_rdata_mux;
    logic                              w_unused;

    assign w_idx      = addr_i[7:2];
    assign w_wdata    = wdata_i[WIDTH-1:0];
    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_unused   = ^{addr_i[31:8], addr_i[1:0], wdata_i};

    // A pin flips its debounced level only after s has disagreed for DEBOUNCE+1 edges.
    // The counter wraps naturally if DEBOUNCE is lowered below a count in flight.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_stb_next = r_stb;
        w_cnt_next = r_cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_sync_out[i] == r_stb[i]) begin
                w_cnt_next[i] = '0;
            end else if (r_cnt[i] == r_debounce) begin
                w_stb_next[i] = w_sync_out[i];
                w_cnt_next[i] = '0;
            end else begin
                w_cnt_next[i] = r_cnt[i] + DB_W'(1);
            end
        end
    end

    assign w_rise = w_stb_next & ~r_stb;
    assign w_fall = ~w_stb_next & r_stb;
    assign w_w1c  = (we_i && (w_idx == A_STATUS)) ? w_wdata : '0;

    // Set events are OR-ed in after the clear so a coincident event wins over W1C.
    assign w_status_next = (r_status & ~w_w1c) | (w_rise & r_rise_en) | (w_fall & r_fall_en);

    always_comb begin
        w_rdata_mux = '0;
        case (w_idx)
            A_DATA:     w_rdata_mux = 32'(r_data);
            A_DIR:      w_rdata_mux = 32'(r_dir);
            A_INPUT:    w_rdata_mux = 32'(r_stb);
            A_RISE_EN:  w_rdata_mux = 32'(r_rise_en);
            A_FALL_EN:  w_rdata_mux = 32'(r_fall_en);
            A_STATUS:   w_rdata_mux = 32'(r_status);
            A_DEBOUNCE: w_rdata_mux = 32'(r_debounce);
            default:    w_rdata_mux = '0;
        endcase
    end

    // Input path: synchroniser, debounce filter, edge status.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop
        // samples pre-edge values regardless of statement order.
        if (rst_i) begin
            r_sync   <= '0;
            r_stb    <= '0;
            r_cnt    <= '0;
            r_status <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], gpio_i};
            r_stb    <= w_stb_next;
            r_cnt    <= w_cnt_next;
            r_status <= w_status_next;
        end
    end

    // Bus-writable registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data     <= '0;
            r_dir      <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_debounce <= DB_W'(DB_RST);
        end else if (we_i) begin
            case (w_idx)
                A_DATA:     r_data     <= w_wdata;
                A_DIR:      r_dir      <= w_wdata;
                A_SET:      r_data     <= r_data | w_wdata;
                A_CLR:      r_data     <= r_data & ~w_wdata;
                A_TOG:      r_data     <= r_data ^ w_wdata;
                A_RISE_EN:  r_rise_en  <= w_wdata;
                A_FALL_EN:  r_fall_en  <= w_wdata;
                A_DEBOUNCE: r_debounce <= wdata_i[DB_W-1:0];
                default:    ;
            endcase
        end
    end

    // Read data is taken from the pre-edge register values, so a same-cycle write
    // to the addressed register returns the old contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata <= '0;
        end else if (re_i) begin
            r_rdata <= w_rdata_mux;
        end
    end

    assign rdata_o   = r_rdata;
    assign gpio_o    = r_data;
    assign gpio_oe_o = r_dir;
    assign irq_o     = |r_status;

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed scenarios plus randomized traffic, all checked each cycle
// against a register-level model whose debounce is a sliding window over pin history.
module tb_gpio_irq;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int DBW  = 8;
    localparam int DBR  = 0;

    localparam logic [7:0] O_DATA   = 8'h00;
    localparam logic [7:0] O_DIR    = 8'h04;
    localparam logic [7:0] O_INPUT  = 8'h08;
    localparam logic [7:0] O_SET    = 8'h0C;
    localparam logic [7:0] O_CLR    = 8'h10;
    localparam logic [7:0] O_TOG    = 8'h14;
    localparam logic [7:0] O_RISE   = 8'h18;
    localparam logic [7:0] O_FALL   = 8'h1C;
    localparam logic [7:0] O_STATUS = 8'h20;
    localparam logic [7:0] O_DEB    = 8'h24;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [31:0]   addr_i;
    logic [31:0]   wdata_i;
    logic          we_i;
    logic          re_i;
    logic [31:0]   rdata_o;
    logic [W-1:0]  gpio_i;
    logic [W-1:0]  gpio_o;
    logic [W-1:0]  gpio_oe_o;
    logic          irq_o;

    always #5 clk_i = ~clk_i;

    gpio_irq #(
        .WIDTH      (W),
        .SYNC_STAGES(SYNC),
        .DB_W       (DBW),
        .DB_RST     (DBR)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .we_i     (we_i),
        .re_i     (re_i),
        .rdata_o  (rdata_o),
        .gpio_i   (gpio_i),
        .gpio_o   (gpio_o),
        .gpio_oe_o(gpio_oe_o),
        .irq_o    (irq_o)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [W-1:0]   m_data, m_dir, m_rise, m_fall, m_status, m_stb;
    logic [DBW-1:0] m_deb;
    logic [31:0]    m_rdata;
    logic [W-1:0]   hist[$];   // pad value seen before each edge since reset

    // True if the synchronised level of pin p equalled v for the last DEBOUNCE+1 edges.
    function automatic bit held(input int p, input logic v);
        for (int j = 0; j <= int'(m_deb); j++) begin
            int idx;
            idx = hist.size() - 1 - SYNC - j;
            if (idx < 0) return 1'b0;
            if (hist[idx][p] !== v) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] off);
        case (off)
            O_DATA:   return 32'(m_data);
            O_DIR:    return 32'(m_dir);
            O_INPUT:  return 32'(m_stb);
            O_RISE:   return 32'(m_rise);
            O_FALL:   return 32'(m_fall);
            O_STATUS: return 32'(m_status);
            O_DEB:    return 32'(m_deb);
            default:  return 32'h0;
        endcase
    endfunction

    // One clock edge: apply the current inputs to the model, then compare outputs.
    task automatic tick();
        logic [31:0]  a, d;
        logic         we, re, rs;
        logic [W-1:0] g, nstb, w1c, dw;
        logic [7:0]   off;
        a = addr_i; d = wdata_i; we = we_i; re = re_i; rs = rst_i; g = gpio_i;
        @(posedge clk_i);
        off = {a[7:2], 2'b00};
        dw  = d[W-1:0];
        if (rs) begin
            m_data = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0;
            m_stb = '0; m_rdata = '0; m_deb = DBW'(DBR);
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back('0);
        end else begin
            hist.push_back(g);
            if (hist.size() > 64) hist.delete(0);
            nstb = m_stb;
            for (int p = 0; p < W; p++)
                if (held(p, ~m_stb[p])) nstb[p] = ~m_stb[p];
            if (re) m_rdata = model_read(off);
            w1c = (we && off == O_STATUS) ? dw : '0;
            m_status = (m_status & ~w1c) | (nstb & ~m_stb & m_rise) | (~nstb & m_stb & m_fall);
            if (we) begin
                case (off)
                    O_DATA: m_data = dw;
                    O_DIR:  m_dir  = dw;
                    O_SET:  m_data = m_data | dw;
                    O_CLR:  m_data = m_data & ~dw;
                    O_TOG:  m_data = m_data ^ dw;
                    O_RISE: m_rise = dw;
                    O_FALL: m_fall = dw;
                    O_DEB:  m_deb  = d[DBW-1:0];
                    default: ;
                endcase
            end
            m_stb = nstb;
        end
        #1;
        check("gpio_o", 32'(gpio_o), 32'(m_data));
        check("gpio_oe_o", 32'(gpio_oe_o), 32'(m_dir));
        check("irq_o", 32'(irq_o), 32'(|m_status));
        check("rdata_o", rdata_o, m_rdata);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        addr_i = {24'h0, off}; wdata_i = d; we_i = 1'b1;
        tick();
        we_i = 1'b0;
    endtask

    task automatic rd(input logic [7:0] off);
        addr_i = {24'h0, off}; re_i = 1'b1;
        tick();
        re_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; we_i = 1'b0; re_i = 1'b0; addr_i = '0; wdata_i = '0; gpio_i = '0;
        idle(2);
        rst_i = 1'b0;
        check("rst_gpio_o", 32'(gpio_o), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);

        // 1: output register atomics
        wr(O_DATA, 32'hA5); check("t1_data", 32'(gpio_o), 32'hA5);
        wr(O_SET, 32'h0F);  check("t1_set", 32'(gpio_o), 32'hAF);
        wr(O_CLR, 32'h81);  check("t1_clr", 32'(gpio_o), 32'h2E);
        wr(O_TOG, 32'hFF);  check("t1_tog", 32'(gpio_o), 32'hD1);
        rd(O_DATA);         check("t1_read", rdata_o, 32'hD1);
        wr(O_DIR, 32'hF0);  check("t1_dir", 32'(gpio_oe_o), 32'hF0);

        // 2: pass-through latency with DEBOUNCE=0
        wr(O_DEB, 32'h0);
        idle(4);
        gpio_i = 8'h5A;
        addr_i = {24'h0, O_INPUT}; re_i = 1'b1;
        tick(); tick(); tick();
        check("t2_early", rdata_o, 32'h0);
        tick();
        check("t2_pass", rdata_o, 32'h5A);
        re_i = 1'b0;

        // 3: debounce threshold 3
        wr(O_DEB, 32'h3);
        gpio_i = 8'h00;
        idle(10);
        gpio_i = 8'h01;
        idle(3);
        gpio_i = 8'h00;
        idle(8);
        rd(O_INPUT);
        check("t3_glitch", rdata_o & 32'h1, 32'h0);
        gpio_i = 8'h01;
        addr_i = {24'h0, O_INPUT}; re_i = 1'b1;
        for (int t = 0; t <= 6; t++) begin
            tick();
            if (t == 5) check("t3_before", rdata_o & 32'h1, 32'h0);
            if (t == 6) check("t3_after", rdata_o & 32'h1, 32'h1);
        end
        re_i = 1'b0;

        // 4: edge status, W1C and irq
        wr(O_DEB, 32'h0);
        gpio_i = 8'h00;
        idle(6);
        wr(O_RISE, 32'h01);
        wr(O_FALL, 32'h02);
        wr(O_STATUS, 32'hFF);
        gpio_i = 8'h03; idle(4);
        gpio_i = 8'h00; idle(4);
        rd(O_STATUS);         check("t4_status", rdata_o, 32'h03);
        check("t4_irq", 32'(irq_o), 32'h1);
        wr(O_STATUS, 32'h01);
        rd(O_STATUS);         check("t4_w1c0", rdata_o, 32'h02);
        check("t4_irq_still", 32'(irq_o), 32'h1);
        wr(O_STATUS, 32'h02); check("t4_irq_off", 32'(irq_o), 32'h0);

        // 5: set beats a coincident W1C
        gpio_i = 8'h01; idle(4);
        gpio_i = 8'h00; idle(4);
        rd(O_STATUS);         check("t5_pre", rdata_o, 32'h01);
        gpio_i = 8'h01;
        tick(); tick();
        wr(O_STATUS, 32'h01);
        rd(O_STATUS);         check("t5_set_wins", rdata_o, 32'h01);

        // 6: reset mid-debounce overrides a concurrent write
        wr(O_DATA, 32'hFF);
        wr(O_DEB, 32'h5);
        gpio_i = 8'h00;
        idle(3);
        rst_i = 1'b1; we_i = 1'b1; addr_i = {24'h0, O_DATA}; wdata_i = 32'h55;
        tick();
        rst_i = 1'b0; we_i = 1'b0;
        check("t6_gpio_o", 32'(gpio_o), 32'h0);
        check("t6_oe", 32'(gpio_oe_o), 32'h0);
        check("t6_irq", 32'(irq_o), 32'h0);
        check("t6_rdata", rdata_o, 32'h0);
        rd(O_DEB);            check("t6_deb", rdata_o, 32'(DBR));
        wr(O_DATA, 32'h77);
        wr(32'h3C, 32'hFFFF_FFFF);
        rd(O_DATA);           check("t6_data", rdata_o, 32'h77);
        rd(8'h3C);            check("t6_unmapped", rdata_o, 32'h0);

        // Randomized traffic; DEBOUNCE is only changed while inputs are settled.
        for (int blk = 0; blk < 6; blk++) begin
            rst_i = 1'b0; we_i = 1'b0; re_i = 1'b0;
            idle(12);
            wr(O_DEB, 32'($urandom_range(0, 5)));
            for (int c = 0; c < 400; c++) begin
                logic [7:0] off;
                rst_i   = ($urandom_range(0, 299) == 0);
                gpio_i  = gpio_i ^ W'($urandom & $urandom & $urandom & $urandom);
                off     = 8'($urandom_range(0, 15) * 4);
                we_i    = ($urandom_range(0, 3) == 0) && (off != O_DEB);
                re_i    = $urandom_range(0, 1) == 1;
                addr_i  = {24'($urandom), off[7:2], 2'($urandom)};
                wdata_i = $urandom;
                tick();
            end
        end
        rst_i = 1'b0; we_i = 1'b0; re_i = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
